// File: rtl/nott_scheduler.sv
// Round-robin scheduler that serialises requesters onto a single NOTT cell:
// optional a-pulse, setup guard, clock pulse, q_evt capture window, response, guard.
module nott_scheduler #(
    parameter int N_REQ = 4,
    parameter int T_AC  = 2,
    parameter int T_CAP = 3,
    parameter int T_CC  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] req_data,
    output logic [N_REQ-1:0] gnt,
    output logic             a_pulse,
    output logic             clk_pulse,
    input  logic             q_evt,
    output logic [N_REQ-1:0] rsp_valid,
    output logic             rsp_data,
    input  logic             err_clr,
    output logic             err_stray,
    output logic             err_mism
);
    localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TMX0 = (T_AC > T_CAP) ? T_AC : T_CAP;
    localparam int TMAX = (TMX0 > T_CC) ? TMX0 : T_CC;
    localparam int CW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_APULSE, S_WAIT_AC, S_CPULSE, S_CAPTURE, S_RESP, S_GUARD
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d, idx_q, idx_d;
    logic            data_q, data_d, cap_q, cap_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_stray_q, err_stray_d, err_mism_q, err_mism_d;
    logic            hit, stray_evt, mism_evt;
    logic [IW-1:0]   pick, cand;

    // First requester at or after ptr, wrapping around.
    always_comb begin
        hit  = 1'b0;
        pick = '0;
        cand = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IW'((int'(ptr_q) + k) % N_REQ);
            if (!hit && req[cand]) begin
                hit  = 1'b1;
                pick = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        data_d    = data_q;
        cap_d     = cap_q;
        cnt_d     = cnt_q;
        gnt       = '0;
        a_pulse   = 1'b0;
        clk_pulse = 1'b0;
        rsp_valid = '0;
        rsp_data  = 1'b0;
        stray_evt = q_evt;
        mism_evt  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hit && rst_n) begin
                    gnt[pick] = 1'b1;
                    idx_d     = pick;
                    data_d    = req_data[pick];
                    ptr_d     = (pick == IW'(N_REQ - 1)) ? '0 : pick + IW'(1);
                    state_d   = req_data[pick] ? S_APULSE : S_CPULSE;
                end
            end
            S_APULSE: begin
                a_pulse = 1'b1;
                if (T_AC == 0) begin
                    state_d = S_CPULSE;
                end else begin
                    state_d = S_WAIT_AC;
                    cnt_d   = CW'(T_AC - 1);
                end
            end
            S_WAIT_AC: begin
                if (cnt_q == '0) state_d = S_CPULSE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_CPULSE: begin
                clk_pulse = 1'b1;
                cap_d     = 1'b0;
                state_d   = S_CAPTURE;
                cnt_d     = CW'(T_CAP - 1);
            end
            S_CAPTURE: begin
                stray_evt = 1'b0;
                cap_d     = cap_q | q_evt;
                if (cnt_q == '0) state_d = S_RESP;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_RESP: begin
                rsp_valid[idx_q] = 1'b1;
                rsp_data         = cap_q;
                // A NOTT cell must invert; an unchanged bit means a bad cell or timing.
                mism_evt         = (cap_q == data_q);
                if (T_CC == 0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_GUARD;
                    cnt_d   = CW'(T_CC - 1);
                end
            end
            S_GUARD: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = S_IDLE;
        endcase
        err_stray_d = (err_stray_q & ~err_clr) | stray_evt;
        err_mism_d  = (err_mism_q & ~err_clr) | mism_evt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            data_q      <= 1'b0;
            cap_q       <= 1'b0;
            cnt_q       <= '0;
            err_stray_q <= 1'b0;
            err_mism_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            cap_q       <= cap_d;
            cnt_q       <= cnt_d;
            err_stray_q <= err_stray_d;
            err_mism_q  <= err_mism_d;
        end
    end

    assign err_stray = err_stray_q;
    assign err_mism  = err_mism_q;
endmodule

// File: doc/nott_scheduler.md
NOTT_SCHEDULER -- requirements
Module: nott_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters.
REQ-002 SHALL have parameter T_AC, default 2: idle cycles between a_pulse and clk_pulse (a-to-clk setup guard).
REQ-003 SHALL have parameter T_CAP, default 3: cycles after clk_pulse during which q_evt is sampled.
REQ-004 SHALL have parameter T_CC, default 2: guard cycles after each response before the next grant (clk-to-clk / clk-to-a spacing).
REQ-005 SHALL have port clk, input, 1: the single clock; all state on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port req, input, N_REQ: level request per requester, held until that requester's rsp_valid bit.
REQ-008 SHALL have port req_data, input, N_REQ: operand bit per requester, valid while req is high.
REQ-009 SHALL have port gnt, output, N_REQ: one-hot, one-cycle grant pulse.
REQ-010 SHALL have port a_pulse, output, 1: one-cycle data pulse to the NOTT cell.
REQ-011 SHALL have port clk_pulse, output, 1: one-cycle clock pulse to the NOTT cell.
REQ-012 SHALL have port q_evt, input, 1: one-cycle indication of a NOTT output pulse.
REQ-013 SHALL have port rsp_valid, output, N_REQ: one-hot, one-cycle response strobe.
REQ-014 SHALL have port rsp_data, output, 1: result bit, valid with rsp_valid.
REQ-015 SHALL have port err_clr, input, 1: synchronous clear of both error flags.
REQ-016 SHALL have port err_stray, output, 1: sticky; q_evt seen outside CAPTURE.
REQ-017 SHALL have port err_mism, output, 1: sticky; captured result differs from NOT of operand.

Function
REQ-018 SHALL implement states IDLE, APULSE, WAIT_AC, CPULSE, CAPTURE, RESP, GUARD.
REQ-019 IDLE with any req bit high SHALL grant round-robin starting at pointer ptr, pulse gnt, latch index and req_data, and set ptr to granted index +1 modulo N_REQ.
REQ-020 After grant, latched data 1 SHALL go to APULSE; data 0 SHALL go directly to CPULSE.
REQ-021 APULSE SHALL assert a_pulse for exactly one cycle, then WAIT_AC for exactly T_AC cycles, then CPULSE.
REQ-022 CPULSE SHALL assert clk_pulse for exactly one cycle, then CAPTURE for exactly T_CAP cycles.
REQ-023 CAPTURE SHALL OR q_evt into a captured bit cleared on entering CAPTURE.
REQ-024 RESP SHALL assert rsp_valid at the latched index for one cycle with rsp_data = captured bit, then GUARD for T_CC cycles, then IDLE.
REQ-025 Latency from gnt cycle G: data 0 -> clk_pulse at G+1, rsp at G+2+T_CAP; data 1 -> a_pulse at G+1, clk_pulse at G+2+T_AC, rsp at G+3+T_AC+T_CAP.
REQ-026 Next grant SHALL be no earlier than rsp cycle + T_CC + 1.
REQ-027 a_pulse and clk_pulse SHALL never be asserted in the same cycle.
REQ-028 q_evt in any state other than CAPTURE SHALL set err_stray and SHALL NOT affect rsp_data.
REQ-029 In RESP, captured bit equal to latched data SHALL set err_mism; rsp_data SHALL still be the captured bit.
REQ-030 err_clr coincident with a new error event SHALL leave the flag set.
REQ-031 Requests dropped after grant SHALL NOT abort the sequence; rsp_valid SHALL still be issued.
REQ-032 T_AC=0 or T_CC=0 SHALL skip WAIT_AC or GUARD respectively; T_CAP SHALL be at least 1.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, ptr=0, and gnt, a_pulse, clk_pulse, rsp_valid, rsp_data, err_stray, err_mism all 0, including mid-sequence; no response SHALL be issued for an aborted operation.

Verification
REQ-034 req=0001, req_data=0000, q_evt at G+3 -> gnt=0001 at G, clk_pulse G+1, no a_pulse, rsp_valid=0001 rsp_data=1 at G+5.
REQ-035 req=0010, req_data=0010, no q_evt -> a_pulse G+1, clk_pulse G+4, rsp_valid=0010 rsp_data=0 at G+8, no errors.
REQ-036 req=1111 held, all data 0 -> grants 0001,0010,0100,1000,0001 in order, consecutive grants 8 cycles apart.
REQ-037 q_evt during GUARD -> err_stray=1 until err_clr; rsp_data of next operation unaffected.
REQ-038 data 1 with q_evt in CAPTURE -> rsp_data=1, err_mism=1.
REQ-039 rst_n low during WAIT_AC -> outputs 0 immediately; no clk_pulse or rsp_valid for that operation; after release, next grant from ptr=0.
